// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests, queues responses for decode.
// Build option IFQ_BYPASS_EN: a response arriving at an empty queue is presented to decode in the same cycle.
module instr_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        dbgFetchState
);
    // Handshakes: a transfer occurs in every cycle where valid and ready are both high. While if_valid=1 and
    // if_ready=0 the head entry is held unchanged. imem responses carry no ready: they arrive in request order.

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetchState_t;

    fetchState_t state, nextState;

    logic [31:0]      pc, respPc;
    logic [OUT_W-1:0] outstanding, dropCnt;
    logic [31:0]      fifoInstr [DEPTH];
    logic [31:0]      fifoPc    [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] fifoCount;

    logic [31:0] inFlight;
    logic        reqFire, respTake, respDec, fifoEmpty, bypass, pushEn, popEn;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (fetch_en)  nextState = FETCH;
            FETCH: if (!fetch_en) nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    assign dbgFetchState = (state == FETCH);

    // Credit: words already queued plus words still in flight may never exceed the queue size.
    assign inFlight       = 32'(fifoCount) + 32'(outstanding);
    assign imem_req_valid = (state == FETCH) && !redirect_valid && (inFlight < DEPTH)
                            && (32'(outstanding) < MAX_OUTSTANDING);
    assign imem_req_addr  = pc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign respDec   = imem_resp_valid && (outstanding != '0);
    assign respTake  = imem_resp_valid && !redirect_valid && (dropCnt == '0);
    assign fifoEmpty = (fifoCount == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = respTake && fifoEmpty;
`else
    assign bypass = 1'b0;
`endif

    assign pushEn = respTake && !(bypass && if_ready);
    assign popEn  = !fifoEmpty && if_ready;

    always_comb begin
        if_valid = !fifoEmpty;
        if_instr = fifoEmpty ? '0 : fifoInstr[rdPtr];
        if_pc    = fifoEmpty ? '0 : fifoPc[rdPtr];
        if (bypass) begin
            if_valid = 1'b1;
            if_instr = imem_resp_data;
            if_pc    = respPc;
        end
        if_pc_plus4 = if_valid ? (if_pc + 32'd4) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            respPc      <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstanding + OUT_W'(reqFire) - OUT_W'(respDec);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the abandoned path.
                pc      <= {redirect_pc[31:2], 2'b00};
                respPc  <= {redirect_pc[31:2], 2'b00};
                dropCnt <= outstanding - OUT_W'(respDec);
            end else begin
                if (reqFire)  pc     <= pc + 32'd4;
                if (respTake) respPc <= respPc + 32'd4;
                if (imem_resp_valid && dropCnt != '0) dropCnt <= dropCnt - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
        end else if (redirect_valid) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + PTR_W'(1);
            if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
            fifoCount <= fifoCount + CNT_W'(pushEn) - CNT_W'(popEn);
        end
    end

    always_ff @(posedge clock) begin
        if (pushEn && !redirect_valid) begin
            fifoInstr[wrPtr] <= imem_resp_data;
            fifoPc[wrPtr]    <= respPc;
        end
    end

    noOverflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(pushEn && !popEn && fifoCount == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: random imem/decode/redirect stimulus against a PC-stream reference model.
// The reference model expects the delivery stream to follow the fetch PC, restarting at each redirect target.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clock, reset_n, fetch_en;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic        dbgFetchState;

    instr_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .dbgFetchState(dbgFetchState)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checkCount = 0;
    int errorCount = 0;
    int cyc = 0;
    int outstandingB = 0;
    int epoch = 0;
    int reqCount = 0;
    int latMin = 1, latMax = 1, readyPct = 100;
    logic [31:0]  modelPc = RESET_PC;
    logic         prevFetchEn = 1'b0;
    logic         holdPending = 1'b0;
    logic [63:0]  holdVal = '0;
    logic [95:0]  expQ[$];    // {pc, instr, arrival cycle}
    logic [127:0] pendQ[$];   // {requested addr, model addr, due cycle, epoch}

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pulseReset(input int lowCycles);
        @(posedge clock); #3;
        reset_n = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        check("rst_if_valid", if_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_if_data", {if_instr, if_pc}, 64'h0);
        check("rst_if_pc_plus4", if_pc_plus4, 0);
        check("rst_fetch_state", dbgFetchState, 0);
        pendQ.delete();
        expQ.delete();
        outstandingB = 0;
        epoch++;
        modelPc = RESET_PC;
        prevFetchEn = 1'b0;
        holdPending = 1'b0;
        repeat (lowCycles) @(posedge clock);
        #3 reset_n = 1'b1;
    endtask

    // ---------------- imem driver ----------------
    initial begin
        logic [127:0] head;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_req_ready  = 1'b0;
        forever begin
            @(posedge clock); #1;
            imem_req_ready = ($urandom_range(99, 0) < readyPct);
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            if (reset_n && pendQ.size() > 0) begin
                head = pendQ[0];
                if (cyc >= int'(head[63:32])) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = memWord(head[127:96]);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [127:0] ent;
        logic [95:0]  e;
        logic [31:0]  p4;
        int           arr;
        if (reset_n) begin
            if (holdPending) begin
                check("stall_hold_valid", if_valid, 1);
                check("stall_hold_data", {if_pc, if_instr}, holdVal);
            end
            holdPending = if_valid && !if_ready && !redirect_valid;
            holdVal = {if_pc, if_instr};

            if (imem_resp_valid && pendQ.size() > 0) begin
                ent = pendQ.pop_front();
                outstandingB--;
                if (int'(ent[31:0]) == epoch && !redirect_valid)
                    expQ.push_back({ent[95:64], memWord(ent[95:64]), 32'(cyc)});
            end

            if (if_valid && if_ready) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("FAIL spurious_delivery pc=%h instr=%h expected=nothing", if_pc, if_instr);
                end else begin
                    e = expQ.pop_front();
                    p4 = e[95:64] + 32'd4;
                    arr = int'(e[31:0]);
                    check("deliver_pc", if_pc, e[95:64]);
                    check("deliver_instr", if_instr, e[63:32]);
                    check("deliver_pc_plus4", if_pc_plus4, p4);
                    check("deliver_latency", (cyc - arr) >= LAT, 1);
                end
            end

            if (imem_req_valid) begin
                check("req_not_on_redirect", redirect_valid, 0);
                check("req_needs_fetch", prevFetchEn, 1);
                if (imem_req_ready) begin
                    check("req_addr", imem_req_addr, modelPc);
                    pendQ.push_back({imem_req_addr, modelPc, 32'(cyc + $urandom_range(latMax, latMin)), 32'(epoch)});
                    modelPc = modelPc + 32'd4;
                    outstandingB++;
                    reqCount++;
                end
            end

            if (redirect_valid) begin
                expQ.delete();
                epoch++;
                modelPc = {redirect_pc[31:2], 2'b00};
            end

            check("credit_bound", (outstandingB + expQ.size()) <= DEPTH, 1);
            check("outstanding_bound", outstandingB <= MAXO, 1);
            prevFetchEn = fetch_en;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r0;
        bit seen;
        reset_n = 1'b0;
        fetch_en = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        pulseReset(2);

        // First fetch: 1-cycle memory, decode always ready
        @(posedge clock); #1;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = imem_resp_valid;
        end
        check("first_resp_seen", seen, 1);
        check("fetch_state_on", dbgFetchState, 1);
`ifndef IFQ_BYPASS_EN
        check("first_no_bypass", if_valid, 0);
        @(negedge clock);
`endif
        check("first_valid", if_valid, 1);
        check("first_pc", if_pc, RESET_PC);
        check("first_instr", if_instr, memWord(RESET_PC));
        check("first_pc_plus4", if_pc_plus4, RESET_PC + 32'd4);
        @(posedge clock);
        r0 = reqCount;
        repeat (8) @(posedge clock);
        check("consecutive_issue", reqCount - r0, 8);

        // Decode stalled: exactly DEPTH requests, head held
        pulseReset(1);
        if_ready = 1'b0;
        r0 = reqCount;
        repeat (12) @(posedge clock);
        #2;
        check("stall_req_count", reqCount - r0, DEPTH);
        check("stall_req_valid", imem_req_valid, 0);
        check("stall_head", {if_pc, if_instr}, {RESET_PC, memWord(RESET_PC)});
        if_ready = 1'b1;
        repeat (10) @(posedge clock);

        // Async reset with two queued words
        pulseReset(1);
        if_ready = 1'b0;
        repeat (3) @(posedge clock);
        #2 check("pre_reset_queued", if_valid, 1);
        pulseReset(2);
        if_ready = 1'b1;
        repeat (10) @(posedge clock);

        // Redirect with 3 outstanding, 3-cycle memory
        latMin = 3; latMax = 3;
        pulseReset(1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clock);
            seen = (outstandingB == 3);
        end
        check("three_outstanding", seen, 1);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0041;
        @(posedge clock); #1 redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock); #2;
            seen = if_valid;
        end
        check("redirect_valid_seen", seen, 1);
        check("redirect_first_pc", if_pc, 32'h0000_0040);

        // PC wrap
        latMin = 1; latMax = 1;
        @(posedge clock); #1 redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(posedge clock); #1 redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock); #2;
            seen = if_valid && (if_pc == 32'hFFFF_FFFC);
        end
        check("wrap_seen", seen, 1);
        check("wrap_pc_plus4", if_pc_plus4, 32'h0);

        // Random traffic
        for (int cfg = 0; cfg < 3; cfg++) begin
            latMin = 1 + cfg;
            latMax = 1 + 2 * cfg;
            readyPct = 100 - 25 * cfg;
            for (int n = 0; n < 800; n++) begin
                @(posedge clock); #1;
                fetch_en = ($urandom_range(99, 0) < 90);
                if_ready = ($urandom_range(99, 0) < 70);
                redirect_valid = ($urandom_range(99, 0) < 4);
                redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                                         : 32'($urandom);
            end
        end

        // Drain
        @(posedge clock); #1;
        fetch_en = 1'b0;
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clock);
            seen = (outstandingB == 0) && (expQ.size() == 0);
        end
        check("drain_complete", seen, 1);
        #2 check("drain_if_valid", if_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the decode stage and supplies its instruction word.
- Owns the fetch PC and issues in-order word requests to instruction memory.
- Buffers returned words with their PC in a small FIFO and hands {instr, pc, pc+4} to decode under a valid/ready handshake.
- Handles branch/jump redirects from decode by flushing the queue and discarding stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 4, max imem requests issued but not yet answered
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
fetch_en  in  1  1 = fetching allowed; 0 = stop issuing new requests
imem_req_valid  out  1  request to instruction memory
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned byte address
imem_resp_valid  in  1  response word present (in order, latency >=1 cycle)
imem_resp_data  in  32  instruction word
redirect_valid  in  1  decode-stage branch/jump taken
redirect_pc  in  32  new fetch PC (bits [1:0] ignored, forced 0)
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts (0 = stall)
if_instr  out  32  instruction word
if_pc  out  32  PC of if_instr
if_pc_plus4  out  32  if_pc + 4, mod 2^32

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=IDLE. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0.
- FSM has two states:
  - IDLE -> FETCH when fetch_en=1. IDLE is always entered for one cycle after reset release.
  - FETCH -> IDLE when fetch_en=0. Already-outstanding responses are still accepted and queued (or dropped if drop_cnt>0).
- Request issue: imem_req_valid=1 iff state=FETCH && !redirect_valid && fifo_count + outstanding < DEPTH && outstanding < MAX_OUTSTANDING.
  - imem_req_addr = pc.
  - On handshake (valid&&ready): pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0), outstanding++.
- Each response cycle: outstanding--.
  - If drop_cnt>0: discard the word, drop_cnt--.
  - Otherwise push {data, resp_pc} into the FIFO; resp_pc is a separate counter that advances +4 per accepted response.
  - The credit rule above guarantees the FIFO never overflows; an overflow is an assertion failure.
- Output: if_valid = FIFO non-empty. Head pops on if_valid&&if_ready. Outputs hold stable while if_valid=1 and if_ready=0.
- Redirect (cycle N):
  - FIFO flushed and if_valid=0 in cycle N+1.
  - pc and resp_pc <= {redirect_pc[31:2], 2'b00}.
  - drop_cnt <= outstanding remaining after any response in cycle N (that response is also discarded).
  - No request is issued in cycle N. The first request at redirect_pc is issued in N+1 at the earliest.
  - A pop in cycle N is still honoured: decode consumed it, and flushing is decode's concern.
- Simultaneous push and pop: both occur and count is unchanged. Push into a full FIFO with a pop in the same cycle is legal.
- Latency, no bypass: response at cycle N -> if_valid at N+1.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset release that belong to pre-reset requests are not tracked; the memory must also be reset.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when the FIFO is empty, drop_cnt=0, no redirect, and imem_resp_valid=1, the response drives if_* combinationally in the same cycle. If if_ready=1 it is consumed without being written; otherwise it is written to the FIFO. Latency is 0 cycles.
- Undefined: all responses pass through the FIFO, latency 1 cycle, and if_* are driven only from registers.

Test Plan:
- Reset release, fetch_en=1, memory ready with 1-cycle latency -> addresses 0x0, 0x4, 0x8... issued on consecutive cycles; decode sees pc 0x0/instr M[0] first, with if_pc_plus4=0x4.
- if_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, then imem_req_valid=0; if_instr held at M[0x0]; on release, words drain in order 0x0..0xC.
- 3 requests outstanding (latency 3), redirect_pc=0x40 -> the next 3 responses are discarded; the first if_valid shows pc 0x40, and no word from 0x0–0x8 reaches decode.
- Redirect in the same cycle as a response and a pop -> the popped word is delivered, the arriving word is dropped, FIFO is empty next cycle, and the next request address is redirect_pc.
- PC at 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; if_pc_plus4 for 0xFFFF_FFFC is 0x0.
- reset_n pulsed low mid-stream with FIFO holding 2 entries -> if_valid=0 and imem_req_valid=0 asynchronously; after release, fetch restarts at RESET_PC. With IFQ_BYPASS_EN, M[0] appears on if_instr in the same cycle as its response.
